instruction_decode: RTL and testbench

- Pipeline stage directly downstream of instruction fetch.
- Accepts the registered instruction/PC/valid from fetch and splits the MIPS fields.
- Reads the 32-entry register file, which lives in this block, and writes it from the writeback port.
- Presents a registered decode bundle to execute, with a one-entry skid buffer so execute can stall without losing a fetched instruction.

---
 rtl/instruction_decode_if.sv | 55 +++++
 rtl/instruction_decode.sv | 199 +++++++++++++++++++
 tb/tb_instruction_decode.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_decode_if.sv
// Fetch/writeback-to-decode and decode-to-execute signal bundle.
// master drives the d_i_* side (fetch, writeback, execute stall); slave is the decode stage.
interface instruction_decode_if #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5
);
  logic [IWIDTH-1:0]   d_i_instr;
  logic [PC_WIDTH-1:0] d_i_pc;
  logic                d_i_ce;
  logic                d_i_valid;
  logic                d_i_stall;
  logic                d_i_flush;
  logic                d_i_wb_we;
  logic [AWIDTH-1:0]   d_i_wb_addr;
  logic [DWIDTH-1:0]   d_i_wb_data;

  logic                d_o_ready;
  logic [PC_WIDTH-1:0] d_o_pc;
  logic [5:0]          d_o_opcode;
  logic [5:0]          d_o_funct;
  logic [4:0]          d_o_shamt;
  logic [DWIDTH-1:0]   d_o_rs_data;
  logic [DWIDTH-1:0]   d_o_rt_data;
  logic [AWIDTH-1:0]   d_o_dest;
  logic [DWIDTH-1:0]   d_o_imm;
  logic                d_o_reg_write;
  logic                d_o_mem_read;
  logic                d_o_mem_write;
  logic                d_o_branch;
  logic                d_o_jump;
  logic                d_o_alu_src;
  logic                d_o_illegal;
  logic                d_o_ce;
  logic                d_o_valid;

  modport master (
    output d_i_instr, d_i_pc, d_i_ce, d_i_valid, d_i_stall, d_i_flush,
           d_i_wb_we, d_i_wb_addr, d_i_wb_data,
    input  d_o_ready, d_o_pc, d_o_opcode, d_o_funct, d_o_shamt, d_o_rs_data,
           d_o_rt_data, d_o_dest, d_o_imm, d_o_reg_write, d_o_mem_read,
           d_o_mem_write, d_o_branch, d_o_jump, d_o_alu_src, d_o_illegal,
           d_o_ce, d_o_valid
  );

  modport slave (
    input  d_i_instr, d_i_pc, d_i_ce, d_i_valid, d_i_stall, d_i_flush,
           d_i_wb_we, d_i_wb_addr, d_i_wb_data,
    output d_o_ready, d_o_pc, d_o_opcode, d_o_funct, d_o_shamt, d_o_rs_data,
           d_o_rt_data, d_o_dest, d_o_imm, d_o_reg_write, d_o_mem_read,
           d_o_mem_write, d_o_branch, d_o_jump, d_o_alu_src, d_o_illegal,
           d_o_ce, d_o_valid
  );
endinterface

// File: rtl/instruction_decode.sv
// MIPS decode stage with in-block regfile: 1-cycle registered bundle; d_i_stall holds outputs and a one-entry
// skid catches one fetch (d_o_ready low while full). `DECODE_WB_BYPASS_EN forwards same-cycle wb data to rs/rt.
module instruction_decode #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int REG_NUM  = 32
) (
  input logic                 d_clk,
  input logic                 d_rst,
  instruction_decode_if.slave dif
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25, FN_SLT = 6'h2A;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          shamt;
    logic [DWIDTH-1:0]   rs_data;
    logic [DWIDTH-1:0]   rt_data;
    logic [AWIDTH-1:0]   dest;
    logic [DWIDTH-1:0]   imm;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic                alu_src;
    logic                illegal;
    logic                ce;
    logic                valid;
  } bundle_t;

  typedef enum logic {SK_EMPTY = 1'b0, SK_FULL = 1'b1} skid_state_e;

  skid_state_e         state_q, state_d;
  logic [IWIDTH-1:0]   skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  bundle_t             out_q, out_d, dec;
  logic [DWIDTH-1:0]   regs_q [REG_NUM];

  logic [IWIDTH-1:0]   src_instr;
  logic [PC_WIDTH-1:0] src_pc;
  logic [5:0]          op, fn;
  logic [15:0]         imm16;
  logic [AWIDTH-1:0]   rs_idx, rt_idx, rd_idx;
  logic [DWIDTH-1:0]   rs_val, rt_val;
  logic                accept;

  assign accept    = dif.d_i_ce & dif.d_i_valid & (state_q == SK_EMPTY);
  // A buffered instruction always drains before anything new from fetch.
  assign src_instr = (state_q == SK_FULL) ? skid_instr_q : dif.d_i_instr;
  assign src_pc    = (state_q == SK_FULL) ? skid_pc_q    : dif.d_i_pc;
  assign op        = src_instr[31:26];
  assign fn        = src_instr[5:0];
  assign imm16     = src_instr[15:0];
  assign rs_idx    = AWIDTH'(src_instr[25:21]);
  assign rt_idx    = AWIDTH'(src_instr[20:16]);
  assign rd_idx    = AWIDTH'(src_instr[15:11]);

  always_comb begin
    rs_val = (rs_idx == '0) ? '0 : regs_q[rs_idx];
    rt_val = (rt_idx == '0) ? '0 : regs_q[rt_idx];
`ifdef DECODE_WB_BYPASS_EN
    if (dif.d_i_wb_we && (dif.d_i_wb_addr != '0)) begin
      if (dif.d_i_wb_addr == rs_idx) rs_val = dif.d_i_wb_data;
      if (dif.d_i_wb_addr == rt_idx) rt_val = dif.d_i_wb_data;
    end
`endif
  end

  always_comb begin
    dec         = '0;
    dec.pc      = src_pc;
    dec.opcode  = op;
    dec.funct   = fn;
    dec.shamt   = src_instr[10:6];
    dec.rs_data = rs_val;
    dec.rt_data = rt_val;
    dec.ce      = 1'b1;
    dec.valid   = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: begin
            dec.reg_write = 1'b1;
            dec.dest      = rd_idx;
          end
          FN_JR:   dec.jump    = 1'b1;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW: begin
        dec.imm       = DWIDTH'($signed(imm16));
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest      = rt_idx;
        dec.mem_read  = (op == OP_LW);
      end
      OP_SW: begin
        dec.imm       = DWIDTH'($signed(imm16));
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.imm    = DWIDTH'($signed(imm16));
        dec.branch = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_LUI: begin
        dec.imm       = (op == OP_LUI) ? DWIDTH'({imm16, 16'h0000}) : DWIDTH'(imm16);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest      = rt_idx;
      end
      OP_J, OP_JAL: begin
        dec.imm  = DWIDTH'(src_instr[25:0]);
        dec.jump = 1'b1;
        if (op == OP_JAL) begin
          dec.reg_write = 1'b1;
          dec.dest      = {AWIDTH{1'b1}};
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // Writes to $0 are architecturally dead; suppress them so execute never sees one.
    if (dec.dest == '0) dec.reg_write = 1'b0;
  end

  always_comb begin
    out_d        = out_q;
    state_d      = state_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (dif.d_i_flush) begin
      out_d   = '0;
      state_d = SK_EMPTY;
    end else if (dif.d_i_stall) begin
      if (accept) begin
        state_d      = SK_FULL;
        skid_instr_d = dif.d_i_instr;
        skid_pc_d    = dif.d_i_pc;
      end
    end else if (state_q == SK_FULL) begin
      out_d   = dec;
      state_d = SK_EMPTY;
    end else if (accept) begin
      out_d = dec;
    end else begin
      out_d = '0;
    end
  end

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      state_q      <= SK_EMPTY;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      out_q        <= out_d;
    end
  end

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (dif.d_i_wb_we && (dif.d_i_wb_addr != '0)) begin
      regs_q[dif.d_i_wb_addr] <= dif.d_i_wb_data;
    end
  end

  assign dif.d_o_ready     = (state_q == SK_EMPTY);
  assign dif.d_o_pc        = out_q.pc;
  assign dif.d_o_opcode    = out_q.opcode;
  assign dif.d_o_funct     = out_q.funct;
  assign dif.d_o_shamt     = out_q.shamt;
  assign dif.d_o_rs_data   = out_q.rs_data;
  assign dif.d_o_rt_data   = out_q.rt_data;
  assign dif.d_o_dest      = out_q.dest;
  assign dif.d_o_imm       = out_q.imm;
  assign dif.d_o_reg_write = out_q.reg_write;
  assign dif.d_o_mem_read  = out_q.mem_read;
  assign dif.d_o_mem_write = out_q.mem_write;
  assign dif.d_o_branch    = out_q.branch;
  assign dif.d_o_jump      = out_q.jump;
  assign dif.d_o_alu_src   = out_q.alu_src;
  assign dif.d_o_illegal   = out_q.illegal;
  assign dif.d_o_ce        = out_q.ce;
  assign dif.d_o_valid     = out_q.valid;
endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed instructions push expected bundles, a monitor pops on each output load.
module tb_instruction_decode;
  logic d_clk = 1'b0;
  logic d_rst = 1'b0;
  always #5 d_clk = ~d_clk;

  instruction_decode_if #(.PC_WIDTH(32), .IWIDTH(32), .DWIDTH(32), .AWIDTH(5)) dif ();

  instruction_decode #(.PC_WIDTH(32), .IWIDTH(32), .DWIDTH(32), .AWIDTH(5), .REG_NUM(32)) dut (
    .d_clk (d_clk),
    .d_rst (d_rst),
    .dif   (dif)
  );

  // ctl = {illegal, reg_write, mem_read, mem_write, branch, jump, alu_src}
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [6:0]  ctl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_a;
  int   total = 0;
  int   bad   = 0;
  logic last_load = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  // A new bundle is expected only after an edge that was neither stalled, flushed nor in reset.
  always @(posedge d_clk) last_load <= d_rst && !dif.d_i_stall && !dif.d_i_flush;

  always @(negedge d_clk) begin
    if (last_load && dif.d_o_valid) begin
      mon_a = {dif.d_o_pc, dif.d_o_opcode, dif.d_o_funct, dif.d_o_shamt, dif.d_o_rs_data,
               dif.d_o_rt_data, dif.d_o_dest, dif.d_o_imm,
               {dif.d_o_illegal, dif.d_o_reg_write, dif.d_o_mem_read, dif.d_o_mem_write,
                dif.d_o_branch, dif.d_o_jump, dif.d_o_alu_src}};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out pc=%h got a valid bundle required none", dif.d_o_pc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL bundle pc=%h got rs=%h rt=%h dest=%0d imm=%h ctl=%b sh=%0d required rs=%h rt=%h dest=%0d imm=%h ctl=%b sh=%0d pc=%h",
                   mon_a.pc, mon_a.rs, mon_a.rt, mon_a.dest, mon_a.imm, mon_a.ctl, mon_a.sh,
                   mon_e.rs, mon_e.rt, mon_e.dest, mon_e.imm, mon_e.ctl, mon_e.sh, mon_e.pc);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge d_clk);
    @(negedge d_clk);
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [4:0] dest, input logic [31:0] imm,
                          input logic [6:0] ctl);
    exp_t e;
    e = '{pc, instr[31:26], instr[5:0], instr[10:6], rs, rt, dest, imm, ctl};
    sb.push_back(e);
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    dif.d_i_instr = instr;
    dif.d_i_pc    = pc;
    dif.d_i_ce    = 1'b1;
    dif.d_i_valid = 1'b1;
  endtask

  task automatic idle_in();
    dif.d_i_ce    = 1'b0;
    dif.d_i_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] dest, input logic [31:0] imm,
                       input logic [6:0] ctl);
    push_exp(instr, pc, rs, rt, dest, imm, ctl);
    present(instr, pc);
    cyc();
    idle_in();
    chk("latency_valid", 64'(dif.d_o_valid), 64'd1);
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    dif.d_i_wb_we   = 1'b1;
    dif.d_i_wb_addr = addr;
    dif.d_i_wb_data = data;
    cyc();
    dif.d_i_wb_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.d_i_instr   = '0;
    dif.d_i_pc      = '0;
    dif.d_i_ce      = 1'b0;
    dif.d_i_valid   = 1'b0;
    dif.d_i_stall   = 1'b0;
    dif.d_i_flush   = 1'b0;
    dif.d_i_wb_we   = 1'b0;
    dif.d_i_wb_addr = '0;
    dif.d_i_wb_data = '0;
    #12;
    chk("rst_ready", 64'(dif.d_o_ready), 64'd1);
    chk("rst_valid", 64'(dif.d_o_valid), 64'd0);
    chk("rst_ce",    64'(dif.d_o_ce),    64'd0);
    chk("rst_pc",    64'(dif.d_o_pc),    64'd0);
    chk("rst_rw",    64'(dif.d_o_reg_write), 64'd0);
    @(negedge d_clk);
    d_rst = 1'b1;
    cyc();

    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    wb(5'd0, 32'hDEAD);

    issue(32'h00221820, 32'h100, 32'd5, 32'd7, 5'd3, 32'd0, 7'b0100000);   // add $3,$1,$2
    cyc();
    chk("bubble_valid", 64'(dif.d_o_valid), 64'd0);
    chk("bubble_ce",    64'(dif.d_o_ce),    64'd0);
    issue(32'h2005FFFC, 32'h104, 32'd0, 32'd0, 5'd5, 32'hFFFFFFFC, 7'b0100001); // addi
    issue(32'h34058000, 32'h108, 32'd0, 32'd0, 5'd5, 32'h00008000, 7'b0100001); // ori
    issue(32'h0C000010, 32'h10C, 32'd0, 32'd0, 5'd31, 32'h10, 7'b0100010);      // jal
    issue(32'hFC000000, 32'h110, 32'd0, 32'd0, 5'd0, 32'd0, 7'b1000000);        // bad opcode
    issue(32'h8C220004, 32'h114, 32'd5, 32'd7, 5'd2, 32'd4, 7'b0110001);        // lw
    issue(32'hAC220008, 32'h118, 32'd5, 32'd7, 5'd0, 32'd8, 7'b0001001);        // sw
    issue(32'h1022FFFE, 32'h11C, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 7'b0000100); // beq
    issue(32'h00220020, 32'h120, 32'd5, 32'd7, 5'd0, 32'd0, 7'b0000000);        // add to $0
    issue(32'h00200008, 32'h124, 32'd5, 32'd0, 5'd0, 32'd0, 7'b0000010);        // jr $1
    issue(32'h00220021, 32'h128, 32'd5, 32'd7, 5'd0, 32'd0, 7'b1000000);        // bad funct
    issue(32'h3C051234, 32'h12C, 32'd0, 32'd0, 5'd5, 32'h12340000, 7'b0100001); // lui
    issue(32'h3025FFFF, 32'h130, 32'd5, 32'd0, 5'd5, 32'h0000FFFF, 7'b0100001); // andi
    issue(32'h00031080, 32'h134, 32'd0, 32'd0, 5'd2, 32'd0, 7'b0100000);        // sll $2,$3,2
    issue(32'h00001820, 32'h138, 32'd0, 32'd0, 5'd3, 32'd0, 7'b0100000);        // $0 reads 0

    // Stall for 3 cycles while fetch offers A then B.
    issue(32'h00221820, 32'h200, 32'd5, 32'd7, 5'd3, 32'd0, 7'b0100000);
    dif.d_i_stall = 1'b1;
    push_exp(32'h34060001, 32'h204, 32'd0, 32'd0, 5'd6, 32'd1, 7'b0100001);
    present(32'h34060001, 32'h204);
    cyc();
    chk("stall_ready_drop", 64'(dif.d_o_ready), 64'd0);
    chk("stall_hold_pc1",   64'(dif.d_o_pc),    64'h200);
    push_exp(32'h20070002, 32'h208, 32'd0, 32'd0, 5'd7, 32'd2, 7'b0100001);
    present(32'h20070002, 32'h208);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_ready_low", 64'(dif.d_o_ready), 64'd0);
      chk("stall_hold_pc",   64'(dif.d_o_pc),    64'h200);
      chk("stall_hold_vld",  64'(dif.d_o_valid), 64'd1);
    end
    dif.d_i_stall = 1'b0;
    cyc();
    chk("release_pc_A",  64'(dif.d_o_pc),    64'h204);
    chk("release_ready", 64'(dif.d_o_ready), 64'd1);
    cyc();
    chk("release_pc_B",  64'(dif.d_o_pc),    64'h208);
    idle_in();
    cyc();
    chk("after_B_bubble", 64'(dif.d_o_valid), 64'd0);

    // Flush with the skid buffer holding an instruction.
    issue(32'h00221820, 32'h300, 32'd5, 32'd7, 5'd3, 32'd0, 7'b0100000);
    dif.d_i_stall = 1'b1;
    present(32'h34060001, 32'h304);
    cyc();
    chk("flush_pre_ready", 64'(dif.d_o_ready), 64'd0);
    idle_in();
    dif.d_i_flush = 1'b1;
    cyc();
    chk("flush_valid", 64'(dif.d_o_valid),     64'd0);
    chk("flush_ready", 64'(dif.d_o_ready),     64'd1);
    chk("flush_rw",    64'(dif.d_o_reg_write), 64'd0);
    chk("flush_ce",    64'(dif.d_o_ce),        64'd0);
    dif.d_i_flush = 1'b0;
    dif.d_i_stall = 1'b0;
    cyc();
    chk("flush_skid_gone", 64'(dif.d_o_valid), 64'd0);
    issue(32'h00221820, 32'h310, 32'd5, 32'd7, 5'd3, 32'd0, 7'b0100000);

    // Writeback to $1 in the same cycle $1 is read.
    dif.d_i_wb_we   = 1'b1;
    dif.d_i_wb_addr = 5'd1;
    dif.d_i_wb_data = 32'd9;
`ifdef DECODE_WB_BYPASS_EN
    issue(32'h00221820, 32'h320, 32'd9, 32'd7, 5'd3, 32'd0, 7'b0100000);
`else
    issue(32'h00221820, 32'h320, 32'd5, 32'd7, 5'd3, 32'd0, 7'b0100000);
`endif
    dif.d_i_wb_we   = 1'b0;
    issue(32'h00221820, 32'h324, 32'd9, 32'd7, 5'd3, 32'd0, 7'b0100000);

    // Asynchronous reset while stalled with the skid full.
    issue(32'h00221820, 32'h330, 32'd9, 32'd7, 5'd3, 32'd0, 7'b0100000);
    dif.d_i_stall = 1'b1;
    present(32'h34060001, 32'h334);
    cyc();
    chk("arst_pre_ready", 64'(dif.d_o_ready), 64'd0);
    #2;
    d_rst = 1'b0;
    #1;
    chk("arst_valid", 64'(dif.d_o_valid),   64'd0);
    chk("arst_pc",    64'(dif.d_o_pc),      64'd0);
    chk("arst_ready", 64'(dif.d_o_ready),   64'd1);
    chk("arst_rs",    64'(dif.d_o_rs_data), 64'd0);
    chk("arst_ce",    64'(dif.d_o_ce),      64'd0);
    @(negedge d_clk);
    d_rst = 1'b1;
    dif.d_i_stall = 1'b0;
    idle_in();
    cyc();
    chk("arst_skid_gone", 64'(dif.d_o_valid), 64'd0);
    issue(32'h00221820, 32'h340, 32'd0, 32'd0, 5'd3, 32'd0, 7'b0100000);

    cyc();
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
